// File: rtl/pllMap_pkg.sv
// rtl/pllMap_pkg.sv - PLL control word, frequency subset, sequencer states and helpers
package pllMap_pkg;

  typedef struct packed {
    logic        pllen;
    logic        powergood_vnn;
    logic        ssc_en;
    logic [7:0]  ssc_spread;
    logic        bypass;
    logic [9:0]  ratio;
    logic [23:0] fraction;
    logic [1:0]  vcodiv_ratio;
    logic [3:0]  zdiv0_ratio;
    logic        zdiv0_ratio_p5;
    logic [3:0]  zdiv1_ratio;
    logic        zdiv1_ratio_p5;
    logic [4:0]  mdiv_ratio;
  } pllmap2pll;

  // Fields that may only change while the PLL is disabled
  typedef struct packed {
    logic [9:0]  ratio;
    logic [23:0] fraction;
    logic [1:0]  vcodiv_ratio;
    logic [3:0]  zdiv0_ratio;
    logic        zdiv0_ratio_p5;
    logic [3:0]  zdiv1_ratio;
    logic        zdiv1_ratio_p5;
    logic [4:0]  mdiv_ratio;
  } pllfreq_t;

  typedef enum logic [3:0] {
    SEQ_RUN       = 4'd0,
    SEQ_GATE      = 4'd1,
    SEQ_OFF       = 4'd2,
    SEQ_LOAD      = 4'd3,
    SEQ_ON        = 4'd4,
    SEQ_WAIT_LOCK = 4'd5,
    SEQ_SETTLE    = 4'd6,
    SEQ_DISABLED  = 4'd7,
    SEQ_ERR       = 4'd8
  } pll_seq_state_e;

  localparam logic [9:0] PLL_RATIO_RST = 10'd20;
  localparam pllfreq_t   PLL_FREQ_RST  = '{ratio: PLL_RATIO_RST, default: '0};

  function automatic pllfreq_t get_freq(input pllmap2pll p);
    pllfreq_t f;
    f.ratio          = p.ratio;
    f.fraction       = p.fraction;
    f.vcodiv_ratio   = p.vcodiv_ratio;
    f.zdiv0_ratio    = p.zdiv0_ratio;
    f.zdiv0_ratio_p5 = p.zdiv0_ratio_p5;
    f.zdiv1_ratio    = p.zdiv1_ratio;
    f.zdiv1_ratio_p5 = p.zdiv1_ratio_p5;
    f.mdiv_ratio     = p.mdiv_ratio;
    return f;
  endfunction

  function automatic pllmap2pll set_freq(input pllmap2pll p, input pllfreq_t f);
    pllmap2pll r;
    r                = p;
    r.ratio          = f.ratio;
    r.fraction       = f.fraction;
    r.vcodiv_ratio   = f.vcodiv_ratio;
    r.zdiv0_ratio    = f.zdiv0_ratio;
    r.zdiv0_ratio_p5 = f.zdiv0_ratio_p5;
    r.zdiv1_ratio    = f.zdiv1_ratio;
    r.zdiv1_ratio_p5 = f.zdiv1_ratio_p5;
    r.mdiv_ratio     = f.mdiv_ratio;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_relock_seq_if.sv
// rtl/pll_relock_seq_if.sv - bundle between register-map core, relock sequencer and PLL macro
interface pll_relock_seq_if;

  pllMap_pkg::pllmap2pll pllcontrol_i;
  logic                  pll_lock_i;
  pllMap_pkg::pllmap2pll pll_o;
  logic                  clk_gate_en_o;
  logic                  busy_o;
  logic                  lock_o;
  logic                  timeout_err_o;

  modport master (
    output pllcontrol_i, pll_lock_i,
    input  pll_o, clk_gate_en_o, busy_o, lock_o, timeout_err_o
  );

  modport slave (
    input  pllcontrol_i, pll_lock_i,
    output pll_o, clk_gate_en_o, busy_o, lock_o, timeout_err_o
  );

endinterface

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the asynchronous PLL lock indication
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_relock_seq.sv
// rtl/pll_relock_seq.sv - PLL relock sequencer; PLL_RELOCK_TIMEOUT_EN adds lock timeout and ERR state
module pll_relock_seq
  import pllMap_pkg::*;
#(
  parameter int OFF_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_TIMEOUT  = 4096
) (
  input logic             clk,
  input logic             rst_n,
  pll_relock_seq_if.slave bus
);

  localparam int CW = $clog2(max3(OFF_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT)) + 1;

  localparam logic [3:0] S_RUN       = SEQ_RUN;
  localparam logic [3:0] S_GATE      = SEQ_GATE;
  localparam logic [3:0] S_OFF       = SEQ_OFF;
  localparam logic [3:0] S_LOAD      = SEQ_LOAD;
  localparam logic [3:0] S_ON        = SEQ_ON;
  localparam logic [3:0] S_WAIT_LOCK = SEQ_WAIT_LOCK;
  localparam logic [3:0] S_SETTLE    = SEQ_SETTLE;
  localparam logic [3:0] S_DISABLED  = SEQ_DISABLED;
  localparam logic [3:0] S_ERR       = SEQ_ERR;

  localparam logic [CW-1:0] GATE_LAST   = CW'(1);
  localparam logic [CW-1:0] OFF_LAST    = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          dis_q, dis_d;
  pllfreq_t      freq_q, freq_d;
  pllfreq_t      freq_in;
  pllmap2pll     pass_q;
  pllmap2pll     pll_w;
  logic          lock_s;
  logic          change;
  logic          run;
  logic          pllen_w;

  pll_lock_sync u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.pll_lock_i),
    .q_o   (lock_s)
  );

  assign freq_in = get_freq(bus.pllcontrol_i);
  assign change  = (freq_in != freq_q);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    dis_d   = dis_q;
    freq_d  = freq_q;
    case (state_q)
      S_RUN: begin
        cnt_d = '0;
        if (!bus.pllcontrol_i.pllen) begin
          state_d = S_GATE;
          dis_d   = 1'b1;
        end else if (change) begin
          state_d = S_GATE;
          dis_d   = 1'b0;
        end else if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end
      end
      S_GATE: begin
        if (cnt_q == GATE_LAST) begin
          state_d = dis_q ? S_DISABLED : S_OFF;
          cnt_d   = '0;
        end
      end
      S_OFF: begin
        if (cnt_q == OFF_LAST) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: state_d = S_ON;
      S_ON: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
      // The cycle lock_s is first seen here counts as the first settle cycle
      S_WAIT_LOCK: begin
        if (lock_s) begin
          if (SETTLE_CYCLES <= 1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_SETTLE;
            cnt_d   = CW'(1);
          end
        end
`ifdef PLL_RELOCK_TIMEOUT_EN
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
`endif
      end
      S_SETTLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= SETTLE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_DISABLED: begin
        if (bus.pllcontrol_i.pllen) state_d = S_LOAD;
      end
`ifdef PLL_RELOCK_TIMEOUT_EN
      S_ERR: begin
        if (!bus.pllcontrol_i.pllen) begin
          state_d = S_DISABLED;
        end else if (change) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = S_WAIT_LOCK;
    endcase
    // Capturing on entry makes the new dividers visible during LOAD itself
    if (state_d == S_LOAD) freq_d = freq_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT_LOCK;
      cnt_q   <= '0;
      dis_q   <= 1'b0;
      freq_q  <= PLL_FREQ_RST;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dis_q   <= dis_d;
      freq_q  <= freq_d;
      pass_q  <= bus.pllcontrol_i;
    end
  end

`ifdef PLL_RELOCK_TIMEOUT_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_d == S_ERR && state_q != S_ERR) begin
      err_d = 1'b1;
    end else if (state_d == S_RUN && state_q != S_RUN) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.timeout_err_o = err_q;
`else
  assign bus.timeout_err_o = 1'b0;
`endif

  assign run     = (state_q == S_RUN);
  assign pllen_w = !(state_q inside {S_OFF, S_LOAD, S_DISABLED, S_ERR});

  always_comb begin
    pll_w               = set_freq(pass_q, freq_q);
    pll_w.pllen         = pllen_w;
    pll_w.powergood_vnn = 1'b1;
    pll_w.ssc_en        = pass_q.ssc_en & run;
  end

  assign bus.pll_o         = pll_w;
  assign bus.clk_gate_en_o = run;
  assign bus.busy_o        = !(run || state_q == S_DISABLED);
  assign bus.lock_o        = lock_s & run;

endmodule

// File: tb/tb_pll_relock_seq.sv
// tb/tb_pll_relock_seq.sv - directed self-checking bench for pll_relock_seq
module tb_pll_relock_seq;
  import pllMap_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   t = 0;

  pll_relock_seq_if bus ();

  pll_relock_seq #(
    .OFF_CYCLES    (16),
    .SETTLE_CYCLES (8),
    .LOCK_TIMEOUT  (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t exp < 100000", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic go_to(input int k);
    while (t < k) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pll_lock_i = 1'b0;
    bus.pllcontrol_i = '0;
    bus.pllcontrol_i.pllen = 1'b1;
    bus.pllcontrol_i.ratio = 10'd20;
    bus.pllcontrol_i.ssc_en = 1'b1;
    bus.pllcontrol_i.ssc_spread = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL rst_pllen: got %b exp 1", bus.pll_o.pllen); end
    tests++; if (bus.pll_o.ratio !== 10'd20) begin fails++; $display("FAIL rst_ratio: got %0d exp 20", bus.pll_o.ratio); end
    tests++; if (bus.pll_o.powergood_vnn !== 1'b1) begin fails++; $display("FAIL rst_pgood: got %b exp 1", bus.pll_o.powergood_vnn); end
    tests++; if (bus.pll_o.ssc_spread !== 8'h00) begin fails++; $display("FAIL rst_spread: got %h exp 00", bus.pll_o.ssc_spread); end
    tests++; if (bus.pll_o.ssc_en !== 1'b0) begin fails++; $display("FAIL rst_ssc_en: got %b exp 0", bus.pll_o.ssc_en); end
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL rst_gate: got %b exp 0", bus.clk_gate_en_o); end
    tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b exp 1", bus.busy_o); end
    tests++; if (bus.lock_o !== 1'b0) begin fails++; $display("FAIL rst_lock: got %b exp 0", bus.lock_o); end
    tests++; if (bus.timeout_err_o !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", bus.timeout_err_o); end
    rst_n = 1'b1;
    t = 0;
  endtask

  task automatic test_lock_from_reset();
    logic       ratio_ok;
    logic [9:0] bad_ratio;
    ratio_ok  = 1'b1;
    bad_ratio = '0;
    for (int k = 0; k <= 16; k++) begin
      go_to(k);
      if (k == 5) bus.pll_lock_i = 1'b1;
      if (bus.pll_o.ratio !== 10'd20) begin ratio_ok = 1'b0; bad_ratio = bus.pll_o.ratio; end
      if (k == 14) begin
        tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL boot_gate_c14: got %b exp 0", bus.clk_gate_en_o); end
        tests++; if (bus.lock_o !== 1'b0) begin fails++; $display("FAIL boot_lock_c14: got %b exp 0", bus.lock_o); end
      end
      if (k == 15) begin
        tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL boot_gate_c15: got %b exp 1", bus.clk_gate_en_o); end
        tests++; if (bus.lock_o !== 1'b1) begin fails++; $display("FAIL boot_lock_c15: got %b exp 1", bus.lock_o); end
        tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL boot_busy_c15: got %b exp 0", bus.busy_o); end
        tests++; if (bus.pll_o.ssc_en !== 1'b1) begin fails++; $display("FAIL boot_ssc_en: got %b exp 1", bus.pll_o.ssc_en); end
        tests++; if (bus.pll_o.ssc_spread !== 8'h5A) begin fails++; $display("FAIL boot_spread: got %h exp 5a", bus.pll_o.ssc_spread); end
      end
    end
    tests++; if (!ratio_ok) begin fails++; $display("FAIL boot_ratio: got %0d exp 20", bad_ratio); end
  endtask

  task automatic test_freq_change();
    t = 0;
    bus.pllcontrol_i.ratio = 10'd32;
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL chg_gate_c0: got %b exp 1", bus.clk_gate_en_o); end
    go_to(1);
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL chg_gate_c1: got %b exp 0", bus.clk_gate_en_o); end
    go_to(2);
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL chg_pllen_c2: got %b exp 1", bus.pll_o.pllen); end
    go_to(3);
    tests++; if (bus.pll_o.pllen !== 1'b0) begin fails++; $display("FAIL chg_pllen_c3: got %b exp 0", bus.pll_o.pllen); end
    bus.pll_lock_i = 1'b0;
    go_to(18);
    tests++; if (bus.pll_o.pllen !== 1'b0) begin fails++; $display("FAIL chg_pllen_c18: got %b exp 0", bus.pll_o.pllen); end
    tests++; if (bus.pll_o.ratio !== 10'd20) begin fails++; $display("FAIL chg_ratio_c18: got %0d exp 20", bus.pll_o.ratio); end
    go_to(19);
    tests++; if (bus.pll_o.ratio !== 10'd32) begin fails++; $display("FAIL chg_ratio_c19: got %0d exp 32", bus.pll_o.ratio); end
    tests++; if (bus.pll_o.pllen !== 1'b0) begin fails++; $display("FAIL chg_pllen_c19: got %b exp 0", bus.pll_o.pllen); end
    go_to(20);
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL chg_pllen_c20: got %b exp 1", bus.pll_o.pllen); end
    go_to(24);
    bus.pll_lock_i = 1'b1;
    go_to(33);
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL chg_gate_c33: got %b exp 0", bus.clk_gate_en_o); end
    go_to(34);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL chg_gate_c34: got %b exp 1", bus.clk_gate_en_o); end
  endtask

  task automatic test_absorb_and_retrigger();
    t = 0;
    bus.pllcontrol_i.fraction = 24'h001234;
    go_to(3);
    bus.pll_lock_i = 1'b0;
    go_to(5);
    bus.pllcontrol_i.ratio = 10'd40;
    go_to(18);
    tests++; if (bus.pll_o.ratio !== 10'd32) begin fails++; $display("FAIL abs_ratio_c18: got %0d exp 32", bus.pll_o.ratio); end
    go_to(19);
    tests++; if (bus.pll_o.ratio !== 10'd40) begin fails++; $display("FAIL abs_ratio_c19: got %0d exp 40", bus.pll_o.ratio); end
    tests++; if (bus.pll_o.fraction !== 24'h001234) begin fails++; $display("FAIL abs_frac_c19: got %h exp 001234", bus.pll_o.fraction); end
    go_to(22);
    bus.pllcontrol_i.ratio = 10'd48;
    go_to(24);
    bus.pll_lock_i = 1'b1;
    go_to(34);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL abs_gate_c34: got %b exp 1", bus.clk_gate_en_o); end
    tests++; if (bus.pll_o.ratio !== 10'd40) begin fails++; $display("FAIL abs_ratio_c34: got %0d exp 40", bus.pll_o.ratio); end
    go_to(35);
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL abs_gate_c35: got %b exp 0", bus.clk_gate_en_o); end
    go_to(37);
    bus.pll_lock_i = 1'b0;
    go_to(52);
    tests++; if (bus.pll_o.ratio !== 10'd40) begin fails++; $display("FAIL abs_ratio_c52: got %0d exp 40", bus.pll_o.ratio); end
    go_to(53);
    tests++; if (bus.pll_o.ratio !== 10'd48) begin fails++; $display("FAIL abs_ratio_c53: got %0d exp 48", bus.pll_o.ratio); end
    go_to(56);
    bus.pll_lock_i = 1'b1;
    go_to(65);
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL abs_gate_c65: got %b exp 0", bus.clk_gate_en_o); end
    go_to(66);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL abs_gate_c66: got %b exp 1", bus.clk_gate_en_o); end
  endtask

  task automatic test_disable();
    t = 0;
    bus.pllcontrol_i.pllen = 1'b0;
    go_to(1);
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL dis_gate_c1: got %b exp 0", bus.clk_gate_en_o); end
    go_to(2);
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL dis_pllen_c2: got %b exp 1", bus.pll_o.pllen); end
    go_to(3);
    tests++; if (bus.pll_o.pllen !== 1'b0) begin fails++; $display("FAIL dis_pllen_c3: got %b exp 0", bus.pll_o.pllen); end
    tests++; if (bus.busy_o !== 1'b0) begin fails++; $display("FAIL dis_busy_c3: got %b exp 0", bus.busy_o); end
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL dis_gate_c3: got %b exp 0", bus.clk_gate_en_o); end
    go_to(4);
    bus.pll_lock_i = 1'b0;
    go_to(6);
    bus.pllcontrol_i.pllen = 1'b1;
    go_to(7);
    tests++; if (bus.pll_o.pllen !== 1'b0) begin fails++; $display("FAIL dis_pllen_c7: got %b exp 0", bus.pll_o.pllen); end
    tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL dis_busy_c7: got %b exp 1", bus.busy_o); end
    go_to(8);
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL dis_pllen_c8: got %b exp 1", bus.pll_o.pllen); end
    go_to(10);
    bus.pll_lock_i = 1'b1;
    go_to(19);
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL dis_gate_c19: got %b exp 0", bus.clk_gate_en_o); end
    go_to(20);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL dis_gate_c20: got %b exp 1", bus.clk_gate_en_o); end
    tests++; if (bus.lock_o !== 1'b1) begin fails++; $display("FAIL dis_lock_c20: got %b exp 1", bus.lock_o); end
  endtask

  task automatic test_timeout();
    t = 0;
    bus.pllcontrol_i.ratio = 10'd56;
    bus.pll_lock_i = 1'b0;
    go_to(84);
    tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL to_busy_c84: got %b exp 1", bus.busy_o); end
    tests++; if (bus.timeout_err_o !== 1'b0) begin fails++; $display("FAIL to_err_c84: got %b exp 0", bus.timeout_err_o); end
    go_to(85);
`ifdef PLL_RELOCK_TIMEOUT_EN
    tests++; if (bus.timeout_err_o !== 1'b1) begin fails++; $display("FAIL to_err_c85: got %b exp 1", bus.timeout_err_o); end
    tests++; if (bus.pll_o.pllen !== 1'b0) begin fails++; $display("FAIL to_pllen_c85: got %b exp 0", bus.pll_o.pllen); end
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL to_gate_c85: got %b exp 0", bus.clk_gate_en_o); end
`else
    tests++; if (bus.timeout_err_o !== 1'b0) begin fails++; $display("FAIL to_err_c85: got %b exp 0", bus.timeout_err_o); end
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL to_pllen_c85: got %b exp 1", bus.pll_o.pllen); end
`endif
    tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL to_busy_c85: got %b exp 1", bus.busy_o); end
    go_to(88);
    bus.pllcontrol_i.ratio = 10'd60;
`ifdef PLL_RELOCK_TIMEOUT_EN
    go_to(104);
    tests++; if (bus.timeout_err_o !== 1'b1) begin fails++; $display("FAIL to_err_c104: got %b exp 1", bus.timeout_err_o); end
    go_to(105);
    tests++; if (bus.pll_o.ratio !== 10'd60) begin fails++; $display("FAIL to_ratio_c105: got %0d exp 60", bus.pll_o.ratio); end
`endif
    go_to(107);
    bus.pll_lock_i = 1'b1;
`ifdef PLL_RELOCK_TIMEOUT_EN
    go_to(116);
    tests++; if (bus.timeout_err_o !== 1'b1) begin fails++; $display("FAIL to_err_c116: got %b exp 1", bus.timeout_err_o); end
    go_to(117);
    tests++; if (bus.timeout_err_o !== 1'b0) begin fails++; $display("FAIL to_err_c117: got %b exp 0", bus.timeout_err_o); end
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL to_gate_c117: got %b exp 1", bus.clk_gate_en_o); end
`else
    go_to(117);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL to_gate_c117: got %b exp 1", bus.clk_gate_en_o); end
    tests++; if (bus.pll_o.ratio !== 10'd56) begin fails++; $display("FAIL to_ratio_c117: got %0d exp 56", bus.pll_o.ratio); end
`endif
    go_to(146);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL to_gate_c146: got %b exp 1", bus.clk_gate_en_o); end
    tests++; if (bus.pll_o.ratio !== 10'd60) begin fails++; $display("FAIL to_ratio_c146: got %0d exp 60", bus.pll_o.ratio); end
    tests++; if (bus.timeout_err_o !== 1'b0) begin fails++; $display("FAIL to_err_c146: got %b exp 0", bus.timeout_err_o); end
  endtask

  task automatic test_lock_drop();
    t = 0;
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL drop_gate_c0: got %b exp 1", bus.clk_gate_en_o); end
    bus.pll_lock_i = 1'b0;
    go_to(2);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL drop_gate_c2: got %b exp 1", bus.clk_gate_en_o); end
    go_to(3);
    bus.pll_lock_i = 1'b1;
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL drop_gate_c3: got %b exp 0", bus.clk_gate_en_o); end
    tests++; if (bus.lock_o !== 1'b0) begin fails++; $display("FAIL drop_lock_c3: got %b exp 0", bus.lock_o); end
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL drop_pllen_c3: got %b exp 1", bus.pll_o.pllen); end
    go_to(12);
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL drop_gate_c12: got %b exp 0", bus.clk_gate_en_o); end
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL drop_pllen_c12: got %b exp 1", bus.pll_o.pllen); end
    tests++; if (bus.pll_o.ratio !== 10'd60) begin fails++; $display("FAIL drop_ratio_c12: got %0d exp 60", bus.pll_o.ratio); end
    go_to(13);
    tests++; if (bus.clk_gate_en_o !== 1'b1) begin fails++; $display("FAIL drop_gate_c13: got %b exp 1", bus.clk_gate_en_o); end
    tests++; if (bus.lock_o !== 1'b1) begin fails++; $display("FAIL drop_lock_c13: got %b exp 1", bus.lock_o); end
  endtask

  task automatic test_reset_mid_sequence();
    t = 0;
    bus.pllcontrol_i.ratio = 10'd70;
    go_to(5);
    tests++; if (bus.pll_o.pllen !== 1'b0) begin fails++; $display("FAIL mid_pllen_off: got %b exp 0", bus.pll_o.pllen); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.pll_o.pllen !== 1'b1) begin fails++; $display("FAIL mid_rst_pllen: got %b exp 1", bus.pll_o.pllen); end
    tests++; if (bus.pll_o.ratio !== 10'd20) begin fails++; $display("FAIL mid_rst_ratio: got %0d exp 20", bus.pll_o.ratio); end
    tests++; if (bus.clk_gate_en_o !== 1'b0) begin fails++; $display("FAIL mid_rst_gate: got %b exp 0", bus.clk_gate_en_o); end
    tests++; if (bus.busy_o !== 1'b1) begin fails++; $display("FAIL mid_rst_busy: got %b exp 1", bus.busy_o); end
    tests++; if (bus.timeout_err_o !== 1'b0) begin fails++; $display("FAIL mid_rst_err: got %b exp 0", bus.timeout_err_o); end
    tests++; if (bus.pll_o.ssc_spread !== 8'h00) begin fails++; $display("FAIL mid_rst_spread: got %h exp 00", bus.pll_o.ssc_spread); end
  endtask

  initial begin
    test_reset();
    test_lock_from_reset();
    test_freq_change();
    test_absorb_and_retrigger();
    test_disable();
    test_timeout();
    test_lock_drop();
    test_reset_mid_sequence();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
